// File: rtl/dmem_bus_responder_pkg.sv
// Shared bus definitions for the data-memory bus: widths, responder states and sizing helpers.
package dmem_bus_responder_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } busStateT;

    // Wide enough to hold the larger of the two latencies.
    function automatic int cntWidth(input int readLat, input int writeLat);
        int maxLat;
        maxLat = (readLat > writeLat) ? readLat : writeLat;
        return (maxLat < 1) ? 1 : $clog2(maxLat + 1);
    endfunction

endpackage

// File: rtl/dmem_bus_responder_if.sv
// Data-memory bus between the granted core (master) and the memory responder (slave).
// Mem_DataMem_Error exists only when DMEM_RANGE_CHECK_EN is defined.
interface dmem_bus_responder_if;
    import dmem_bus_responder_pkg::*;

    logic              Mem_DataMem_Read;
    logic [BE_W-1:0]   Mem_DataMem_Write;
    logic [ADDR_W-1:0] Mem_DataMem_Address;
    logic [DATA_W-1:0] Mem_DataMem_Out;
    logic [DATA_W-1:0] Mem_DataMem_In;
    logic              Mem_DataMem_Ready;
`ifdef DMEM_RANGE_CHECK_EN
    logic              Mem_DataMem_Error;

    modport master (
        output Mem_DataMem_Read, Mem_DataMem_Write, Mem_DataMem_Address, Mem_DataMem_Out,
        input  Mem_DataMem_In, Mem_DataMem_Ready, Mem_DataMem_Error
    );
    modport slave (
        input  Mem_DataMem_Read, Mem_DataMem_Write, Mem_DataMem_Address, Mem_DataMem_Out,
        output Mem_DataMem_In, Mem_DataMem_Ready, Mem_DataMem_Error
    );
`else
    modport master (
        output Mem_DataMem_Read, Mem_DataMem_Write, Mem_DataMem_Address, Mem_DataMem_Out,
        input  Mem_DataMem_In, Mem_DataMem_Ready
    );
    modport slave (
        input  Mem_DataMem_Read, Mem_DataMem_Write, Mem_DataMem_Address, Mem_DataMem_Out,
        output Mem_DataMem_In, Mem_DataMem_Ready
    );
`endif

endinterface

// File: rtl/dmem_bus_responder_ram.sv
// dmem_ram: single-port synchronous RAM, one-cycle registered read, per-byte write enables.
module dmem_ram
    import dmem_bus_responder_pkg::*;
#(
    parameter int    ADDR_BITS = 10,
    parameter string INIT_FILE = ""
) (
    input  logic                 clock,
    input  logic [BE_W-1:0]      writeEn,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    writeData,
    output logic [DATA_W-1:0]    readData
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clock) begin
        for (int i = 0; i < BE_W; i++) begin
            if (writeEn[i]) begin
                mem[addr][8*i +: 8] <= writeData[8*i +: 8];
            end
        end
        readData <= mem[addr];
    end

endmodule

// File: rtl/dmem_bus_responder.sv
// Memory-side responder for the shared data bus: one word transaction at a time with fixed latency.
// Optional DMEM_RANGE_CHECK_EN flags out-of-range addresses on Mem_DataMem_Error instead of wrapping.
module dmem_bus_responder
    import dmem_bus_responder_pkg::*;
#(
    parameter int    ADDR_BITS     = 10,
    parameter int    READ_LATENCY  = 2,
    parameter int    WRITE_LATENCY = 1,
    parameter string INIT_FILE     = ""
) (
    input  logic                clock,
    input  logic                reset,
    dmem_bus_responder_if.slave bus
);

    localparam int CNT_W = cntWidth(READ_LATENCY, WRITE_LATENCY);

    busStateT             state, stateNext;
    logic [CNT_W-1:0]     cnt, cntNext;
    logic                 accept;
    logic                 isWriteReq;
    logic                 addrOutOfRange;

    logic [ADDR_BITS-1:0] addrLat;
    logic [DATA_W-1:0]    dataLat;
    logic [BE_W-1:0]      beLat;
    logic                 opWriteLat;
    logic                 rangeErrLat;

    logic                 commit;
    logic [BE_W-1:0]      ramWe;
    logic [DATA_W-1:0]    ramRdata;

    assign isWriteReq = |bus.Mem_DataMem_Write;

`ifdef DMEM_RANGE_CHECK_EN
    assign addrOutOfRange = |bus.Mem_DataMem_Address[ADDR_W-1:ADDR_BITS];
`else
    // Upper address bits are deliberately ignored so accesses wrap modulo the RAM depth.
    logic unusedAddrHi;
    assign unusedAddrHi   = |bus.Mem_DataMem_Address[ADDR_W-1:ADDR_BITS];
    assign addrOutOfRange = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Mem_DataMem_Read || isWriteReq) begin
                    accept    = 1'b1;
                    stateNext = WAIT;
                    cntNext   = isWriteReq ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    stateNext = RESP;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            RESP: stateNext = DONE;
            DONE: begin
                if (!bus.Mem_DataMem_Read && !isWriteReq) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request capture: a write request takes priority over a simultaneous read.
    always_ff @(posedge clock) begin
        if (accept) begin
            addrLat     <= bus.Mem_DataMem_Address[ADDR_BITS-1:0];
            dataLat     <= bus.Mem_DataMem_Out;
            beLat       <= bus.Mem_DataMem_Write;
            opWriteLat  <= isWriteReq;
            rangeErrLat <= addrOutOfRange;
        end
    end

    // Write lands on the edge entering RESP; a reset on that same edge discards it.
    assign commit = (state == WAIT) && (cnt == '0) && opWriteLat && !rangeErrLat && !reset;
    assign ramWe  = commit ? beLat : '0;

    dmem_ram #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) uRam (
        .clock     (clock),
        .writeEn   (ramWe),
        .addr      (addrLat),
        .writeData (dataLat),
        .readData  (ramRdata)
    );

    assign bus.Mem_DataMem_Ready = (state == RESP);
    assign bus.Mem_DataMem_In    = ((state == RESP) && !opWriteLat && !rangeErrLat) ? ramRdata : '0;
`ifdef DMEM_RANGE_CHECK_EN
    assign bus.Mem_DataMem_Error = (state == RESP) && rangeErrLat;
`endif

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Directed bench for dmem_bus_responder (ADDR_BITS=10, READ_LATENCY=2, WRITE_LATENCY=1).
// Scenario 6 follows DMEM_RANGE_CHECK_EN: error flag when defined, address wrap otherwise.
module tb_dmem_bus_responder;

    logic clock;
    logic reset;
    int   checkCnt;
    int   passCnt;

    dmem_bus_responder_if bus();

    dmem_bus_responder #(
        .ADDR_BITS     (10),
        .READ_LATENCY  (2),
        .WRITE_LATENCY (1),
        .INIT_FILE     ("")
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic errOut();
`ifdef DMEM_RANGE_CHECK_EN
        return bus.Mem_DataMem_Error;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one request, waits (bounded) for Ready, records what was seen, then releases the bus.
    task automatic doTxn(input logic rd, input logic [3:0] be, input logic [29:0] addr,
                         input logic [31:0] data, output int lat, output logic [31:0] rdData,
                         output logic errSeen, output logic readyAfter, output logic [31:0] inAfter);
        @(posedge clock); #1;
        bus.Mem_DataMem_Read    = rd;
        bus.Mem_DataMem_Write   = be;
        bus.Mem_DataMem_Address = addr;
        bus.Mem_DataMem_Out     = data;
        @(posedge clock);
        lat = 0;
        while (lat < 50) begin
            @(negedge clock);
            if (bus.Mem_DataMem_Ready === 1'b1) break;
            lat++;
        end
        rdData  = bus.Mem_DataMem_In;
        errSeen = errOut();
        @(negedge clock);
        readyAfter = bus.Mem_DataMem_Ready;
        inAfter    = bus.Mem_DataMem_In;
        bus.Mem_DataMem_Read  = 1'b0;
        bus.Mem_DataMem_Write = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Mem_DataMem_Read    = 1'b0;
        bus.Mem_DataMem_Write   = 4'h0;
        bus.Mem_DataMem_Address = '0;
        bus.Mem_DataMem_Out     = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkCnt++;
        if (bus.Mem_DataMem_Ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.Mem_DataMem_Ready);
        else passCnt++;
        checkCnt++;
        if (bus.Mem_DataMem_In !== 32'h0) $display("FAIL reset_in: got %h expected 00000000", bus.Mem_DataMem_In);
        else passCnt++;
        checkCnt++;
        if (errOut() !== 1'b0) $display("FAIL reset_error: got %b expected 0", errOut());
        else passCnt++;
        reset = 1'b0;
    endtask

    task automatic test_read_latency();
        int lat; logic [31:0] d, ia; logic e, ra;
        doTxn(1'b0, 4'hF, 30'h5, 32'hDEADBEEF, lat, d, e, ra, ia);
        checkCnt++;
        if (lat !== 1) $display("FAIL write_latency: got %0d expected 1", lat);
        else passCnt++;
        doTxn(1'b1, 4'h0, 30'h5, 32'h0, lat, d, e, ra, ia);
        checkCnt++;
        if (lat !== 2) $display("FAIL read_latency: got %0d expected 2", lat);
        else passCnt++;
        checkCnt++;
        if (d !== 32'hDEADBEEF) $display("FAIL read_data: got %h expected deadbeef", d);
        else passCnt++;
        checkCnt++;
        if (ra !== 1'b0) $display("FAIL read_ready_one_cycle: got %b expected 0", ra);
        else passCnt++;
        checkCnt++;
        if (ia !== 32'h0) $display("FAIL read_in_after: got %h expected 00000000", ia);
        else passCnt++;
    endtask

    task automatic test_byte_write();
        int lat; logic [31:0] d, ia; logic e, ra;
        doTxn(1'b0, 4'hF, 30'h7, 32'h11223344, lat, d, e, ra, ia);
        doTxn(1'b0, 4'b0101, 30'h7, 32'hAABBCCDD, lat, d, e, ra, ia);
        checkCnt++;
        if (d !== 32'h0) $display("FAIL byte_write_in: got %h expected 00000000", d);
        else passCnt++;
        doTxn(1'b1, 4'h0, 30'h7, 32'h0, lat, d, e, ra, ia);
        checkCnt++;
        if (d !== 32'h11BB33DD) $display("FAIL byte_write_merge: got %h expected 11bb33dd", d);
        else passCnt++;
    endtask

    task automatic test_write_priority();
        int lat; logic [31:0] d, ia; logic e, ra;
        doTxn(1'b0, 4'hF, 30'h9, 32'h01010101, lat, d, e, ra, ia);
        doTxn(1'b1, 4'hF, 30'h9, 32'hCAFEF00D, lat, d, e, ra, ia);
        checkCnt++;
        if (lat !== 1) $display("FAIL priority_latency: got %0d expected 1", lat);
        else passCnt++;
        checkCnt++;
        if (d !== 32'h0) $display("FAIL priority_in: got %h expected 00000000", d);
        else passCnt++;
        doTxn(1'b1, 4'h0, 30'h9, 32'h0, lat, d, e, ra, ia);
        checkCnt++;
        if (d !== 32'hCAFEF00D) $display("FAIL priority_readback: got %h expected cafef00d", d);
        else passCnt++;
    endtask

    task automatic test_held_request();
        int lat, pulses; logic [31:0] d, ia; logic e, ra;
        @(posedge clock); #1;
        bus.Mem_DataMem_Read    = 1'b1;
        bus.Mem_DataMem_Address = 30'h5;
        @(posedge clock);
        lat = 0;
        while (lat < 50) begin
            @(negedge clock);
            if (bus.Mem_DataMem_Ready === 1'b1) break;
            lat++;
        end
        checkCnt++;
        if (lat !== 2) $display("FAIL held_latency: got %0d expected 2", lat);
        else passCnt++;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (bus.Mem_DataMem_Ready === 1'b1) pulses++;
        end
        checkCnt++;
        if (pulses !== 0) $display("FAIL held_extra_ready: got %0d expected 0", pulses);
        else passCnt++;
        bus.Mem_DataMem_Read = 1'b0;
        doTxn(1'b1, 4'h0, 30'h7, 32'h0, lat, d, e, ra, ia);
        checkCnt++;
        if (lat !== 2 || d !== 32'h11BB33DD)
            $display("FAIL held_next_read: got lat %0d data %h expected lat 2 data 11bb33dd", lat, d);
        else passCnt++;
    endtask

    task automatic test_reset_mid_write();
        int lat, pulses; logic [31:0] d, ia; logic e, ra;
        doTxn(1'b0, 4'hF, 30'h3, 32'h12345678, lat, d, e, ra, ia);
        @(posedge clock); #1;
        bus.Mem_DataMem_Write   = 4'hF;
        bus.Mem_DataMem_Address = 30'h3;
        bus.Mem_DataMem_Out     = 32'hFFFFFFFF;
        @(posedge clock); #1;
        reset = 1'b1;
        bus.Mem_DataMem_Write = 4'h0;
        pulses = 0;
        @(negedge clock);
        if (bus.Mem_DataMem_Ready === 1'b1) pulses++;
        @(negedge clock);
        if (bus.Mem_DataMem_Ready === 1'b1) pulses++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (bus.Mem_DataMem_Ready === 1'b1) pulses++;
        end
        checkCnt++;
        if (pulses !== 0) $display("FAIL reset_mid_ready: got %0d pulses expected 0", pulses);
        else passCnt++;
        doTxn(1'b1, 4'h0, 30'h3, 32'h0, lat, d, e, ra, ia);
        checkCnt++;
        if (d !== 32'h12345678) $display("FAIL reset_mid_ram: got %h expected 12345678", d);
        else passCnt++;
        checkCnt++;
        if (lat !== 2) $display("FAIL reset_mid_next_latency: got %0d expected 2", lat);
        else passCnt++;
    endtask

    task automatic test_range();
        int lat; logic [31:0] d, ia; logic e, ra;
        doTxn(1'b0, 4'hF, 30'h0, 32'h01020304, lat, d, e, ra, ia);
        doTxn(1'b0, 4'hF, 30'h400, 32'h55AA55AA, lat, d, e, ra, ia);
        checkCnt++;
        if (lat !== 1) $display("FAIL range_latency: got %0d expected 1", lat);
        else passCnt++;
`ifdef DMEM_RANGE_CHECK_EN
        checkCnt++;
        if (e !== 1'b1) $display("FAIL range_error: got %b expected 1", e);
        else passCnt++;
        doTxn(1'b1, 4'h0, 30'h0, 32'h0, lat, d, e, ra, ia);
        checkCnt++;
        if (d !== 32'h01020304) $display("FAIL range_ram0: got %h expected 01020304", d);
        else passCnt++;
        checkCnt++;
        if (e !== 1'b0) $display("FAIL range_error_inrange: got %b expected 0", e);
        else passCnt++;
`else
        doTxn(1'b1, 4'h0, 30'h0, 32'h0, lat, d, e, ra, ia);
        checkCnt++;
        if (d !== 32'h55AA55AA) $display("FAIL wrap_write_ram0: got %h expected 55aa55aa", d);
        else passCnt++;
        doTxn(1'b1, 4'h0, 30'h405, 32'h0, lat, d, e, ra, ia);
        checkCnt++;
        if (d !== 32'hDEADBEEF) $display("FAIL wrap_read_ram5: got %h expected deadbeef", d);
        else passCnt++;
`endif
    endtask

    initial begin
        checkCnt = 0;
        passCnt  = 0;
        test_reset();
        test_read_latency();
        test_byte_write();
        test_write_priority();
        test_held_request();
        test_reset_mid_write();
        test_range();
        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
